// File: rtl/i2s_pkg.sv
// Shared constants and tracker state encodings for the I2S serializer.
package i2s_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // Tracks the lrclk edge -> bclk rise -> bclk fall sequence, which marks the
  // falling bclk edge where the MSB of a new word has to be presented.
  typedef enum logic [1:0] {
    TRK_IDLE      = 2'b00,
    TRK_ARMED     = 2'b01,
    TRK_SEEN_RISE = 2'b10,
    TRK_FIRE      = 2'b11
  } tracker_state_e;

endpackage

// File: rtl/i2s_first_bclk_detect.sv
// Detects the first bclk falling edge after a chosen lrclk edge. This is the
// one-bclk delay that standard I2S puts between the word clock and the MSB.
module i2s_first_bclk_detect
  import i2s_pkg::*;
#(
  parameter logic LR_RISING = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lrclk_rise,
  input  logic lrclk_fall,
  input  logic bclk_rise,
  input  logic bclk_fall,
  output logic fire
);

  tracker_state_e state;
  tracker_state_e state_next;
  logic           lr_edge;

  assign lr_edge = LR_RISING ? lrclk_rise : lrclk_fall;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= TRK_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A fresh lrclk edge restarts the sequence from any state.
  always_comb begin
    state_next = state;
    if (lr_edge) begin
      state_next = TRK_ARMED;
    end else begin
      case (state)
        TRK_ARMED:     if (bclk_rise) state_next = TRK_SEEN_RISE;
        TRK_SEEN_RISE: if (bclk_fall) state_next = TRK_FIRE;
        TRK_FIRE:      state_next = TRK_IDLE;
        default:       state_next = TRK_IDLE;
      endcase
    end
  end

  // FIRE lasts exactly one clk and acts as the load strobe.
  always_comb begin
    fire = (state == TRK_FIRE);
  end

endmodule

// File: rtl/i2s_shift_out.sv
// I2S transmitter in slave mode: follows external bclk/lrclk, pops one
// left/right pair from the FIFO per frame and shifts it out MSB first.
module i2s_shift_out
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_left_data,
  input  logic [DATA_WIDTH-1:0] fifo_right_data,
  input  logic                  fifo_ready,
  output logic                  fifo_read,
  output logic                  underrun,
  input  logic                  enable,
  input  logic                  bclk,
  input  logic                  lrclk,
  output logic                  data_out
);

  logic                  bclk_d;
  logic                  lrclk_d;
  logic                  bclk_rise;
  logic                  bclk_fall;
  logic                  lrclk_rise;
  logic                  lrclk_fall;
  logic                  left_fire;
  logic                  right_fire;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  hold_valid;

  // One-clk delayed copies of the serial clocks for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_d  <= 1'b0;
      lrclk_d <= 1'b0;
    end else begin
      bclk_d  <= bclk;
      lrclk_d <= lrclk;
    end
  end

  assign bclk_rise  = bclk & ~bclk_d;
  assign bclk_fall  = ~bclk & bclk_d;
  assign lrclk_rise = lrclk & ~lrclk_d;
  assign lrclk_fall = ~lrclk & lrclk_d;

  i2s_first_bclk_detect #(
    .LR_RISING (1'b0)
  ) u_left_load (
    .clk        (clk),
    .reset_n    (reset_n),
    .lrclk_rise (lrclk_rise),
    .lrclk_fall (lrclk_fall),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .fire       (left_fire)
  );

  i2s_first_bclk_detect #(
    .LR_RISING (1'b1)
  ) u_right_load (
    .clk        (clk),
    .reset_n    (reset_n),
    .lrclk_rise (lrclk_rise),
    .lrclk_fall (lrclk_fall),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .fire       (right_fire)
  );

  // Shift/load datapath; hold_valid stops a right slot from replaying a word
  // that was captured before the last reset or disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else if (!enable) begin
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else if (left_fire) begin
      if (fifo_ready) begin
        shift_reg <= fifo_left_data;
        hold_reg  <= fifo_right_data;
      end else begin
        shift_reg <= '0;
        hold_reg  <= '0;
      end
      hold_valid <= 1'b1;
    end else if (right_fire) begin
      shift_reg <= hold_valid ? hold_reg : '0;
    end else if (bclk_fall) begin
      shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // FIFO handshake strobes coincide with the single LEFT_LOAD FIRE clk.
  always_comb begin
    fifo_read = enable & left_fire & fifo_ready;
    underrun  = enable & left_fire & ~fifo_ready;
  end

  assign data_out = shift_reg[DATA_WIDTH-1];

endmodule

// File: doc/i2s_shift_out.md
I2S_SHIFT_OUT -- requirements
Module: i2s_shift_out

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (master clock) and reset_n.
REQ-002 The block SHALL have one parameter: DATA_WIDTH, default 32, sample width in bits.
REQ-003 clk  input  1  master clock, synchronous with bclk/lrclk, at least 8x bclk.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 fifo_left_data  input  DATA_WIDTH  left sample at FIFO head, MSB-aligned.
REQ-006 fifo_right_data  input  DATA_WIDTH  right sample at FIFO head, MSB-aligned.
REQ-007 fifo_ready  input  1  FIFO not empty; head pair valid.
REQ-008 fifo_read  output  1  one-clk pop strobe, asserted when a pair is consumed.
REQ-009 underrun  output  1  one-clk pulse when a pair is due but fifo_ready=0.
REQ-010 enable  input  1  software enable.
REQ-011 bclk  input  1  I2S bit clock, external master.
REQ-012 lrclk  input  1  I2S word clock; low=left, high=right.
REQ-013 data_out  output  1  serial data to DAC, MSB first.

Function
REQ-014 bclk and lrclk SHALL each be registered once in clk; rising/falling edge strobes derive from current vs delayed value.
REQ-015 Each lrclk edge SHALL arm a 2-bit tracker: ARMED(01) -> on bclk rise -> SEEN_RISE(10) -> on bclk fall -> FIRE(11) -> next clk -> IDLE(00); a new same-polarity lrclk edge restarts the tracker at ARMED from any state.
REQ-016 There SHALL be two independent trackers: LEFT_LOAD (lrclk falling) and RIGHT_LOAD (lrclk rising), giving the one-bclk I2S delay.
REQ-017 In the clk where LEFT_LOAD is FIRE, with enable=1 and fifo_ready=1: the shift register SHALL load fifo_left_data, the right holding register SHALL load fifo_right_data, and fifo_read SHALL be 1 for exactly that clk.
REQ-018 In the LEFT_LOAD FIRE clk, with fifo_ready=0: the shift register and the right holding register SHALL load zero, fifo_read SHALL stay 0, and underrun SHALL pulse for one clk.
REQ-019 In the RIGHT_LOAD FIRE clk: the shift register SHALL load the right holding register.
REQ-020 On any other bclk falling edge: the shift register SHALL shift left by one, inserting 0.
REQ-021 Priority SHALL be: ~enable, then load, then shift.
REQ-022 data_out SHALL equal shift register MSB, giving a valid first bit within 3 clk of the bclk falling edge at the pins.
REQ-023 Frames longer than DATA_WIDTH bclks SHALL output 0 after the LSB; shorter frames SHALL truncate the LSBs.
REQ-024 With enable=0: the shift register, right holding register and data_out SHALL be held at 0, and fifo_read and underrun SHALL be 0.
REQ-025 With enable=0, the trackers SHALL keep running.
REQ-026 When enable rises mid-frame, the block SHALL output zeros until the next LEFT_LOAD FIRE.
REQ-027 fifo_read SHALL never assert more than once per lrclk period.

Reset
REQ-028 While reset_n=0: all registers SHALL be 0, data_out=0, fifo_read=0, underrun=0, and both trackers SHALL be IDLE.
REQ-029 Reset SHALL take effect asynchronously, including mid-word; the first load after release SHALL be a LEFT_LOAD, never a RIGHT_LOAD from stale holding data.
REQ-030 To meet REQ-029, the right holding register SHALL be tagged valid only after a LEFT_LOAD since reset/enable; otherwise RIGHT_LOAD SHALL load zero.

Structure
REQ-031 Package i2s_pkg SHALL hold the DATA_WIDTH default and the tracker state encodings (IDLE/ARMED/SEEN_RISE/FIRE).
REQ-032 Sub-module i2s_first_bclk_detect (edge polarity parameter, one tracker) SHALL be instantiated twice.

Verification
REQ-033 Bench SHALL cover: FIFO holds L=0xA5A5_0001, R=0x5A5A_8000, 32-bit frames -> data_out shows A5A50001 MSB-first starting at the 2nd bclk of lrclk-low, then 5A5A8000; one fifo_read pulse.
REQ-034 Bench SHALL cover: fifo_ready=0 at left load -> 64 zero bits, one underrun pulse, no fifo_read.
REQ-035 Bench SHALL cover: 24-bclk half-frames, L=0xFFFFFF00 -> data_out shows 24 ones, then the right word starts.
REQ-036 Bench SHALL cover: enable dropped mid-left-word -> data_out=0 within 1 clk; re-enabled mid-right-word -> zeros until the next left word.
REQ-037 Bench SHALL cover: reset_n pulsed mid-right-word -> outputs 0 immediately; the next right slot after release carries 0, not stale data.
REQ-038 Bench SHALL cover: 3 FIFO pairs back-to-back -> exactly 3 fifo_read pulses, one per lrclk period, with data in order.
